// File: rtl/rng_pkg.sv
// Shared types and constants for the LFSR random number generator.
// The seed-load feature of lfsr_random_gen is enabled by defining RNG_SEED_LOAD_EN.
package rng_pkg;

  // Request FSM: IDLE waits for a request, DIV runs the divider, DONE presents the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } rng_state_e;

  // x^32 + x^22 + x^2 + x + 1, Fibonacci feedback mask.
  localparam logic [31:0] RNG_DEFAULT_TAPS = 32'h80200003;
  localparam logic [31:0] RNG_DEFAULT_SEED = 32'h00004C93;

  // Keep only the low w bits of a seed; an all-zero seed would lock the LFSR, so use 1.
  function automatic logic [31:0] nonzero_seed(input logic [31:0] s, input int w);
    logic [31:0] mask;
    logic [31:0] v;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    v    = s & mask;
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/lfsr_random_gen_lfsr_core.sv
// Free-running Fibonacci LFSR with zero-guarded reset and load values.
module lfsr_core
  import rng_pkg::*;
#(
  parameter int          WIDTH = 32,
  parameter logic [31:0] TAPS  = RNG_DEFAULT_TAPS,
  parameter logic [31:0] SEED  = RNG_DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] TAP_MASK  = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(nonzero_seed(SEED, WIDTH));

  logic [WIDTH-1:0] load_nz;

  // A zero load value is replaced by 1 so the register can never stall at zero.
  assign load_nz = WIDTH'(nonzero_seed(32'(load_val), WIDTH));

  // Shift every cycle; a load takes the place of the shift for that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RESET_VAL;
    end else if (load) begin
      state <= load_nz;
    end else begin
      state <= {state[WIDTH-2:0], ^(state & TAP_MASK)};
    end
  end

endmodule

// File: rtl/lfsr_random_gen.sv
// Pseudo-random generator: free-running LFSR, sampled on each rising edge of enable
// and reduced to [0, max_value] by a restoring divider (remainder of lfsr / (max_value+1)).
// Define RNG_SEED_LOAD_EN to add the seed_load / seed_in ports.
//
// Handshake: each 0->1 transition of enable is one request. busy is high from the cycle
// after the request is accepted up to and including the cycle in which valid is high.
// valid is a single-cycle pulse marking the cycle random_output first shows a new result.
// Edges seen while busy is high are dropped, never queued.
module lfsr_random_gen
  import rng_pkg::*;
#(
  parameter int          WIDTH = 32,
  parameter logic [31:0] TAPS  = RNG_DEFAULT_TAPS,
  parameter logic [31:0] SEED  = RNG_DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] max_value,
`ifdef RNG_SEED_LOAD_EN
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
`endif
  output logic [WIDTH-1:0] random_output,
  output logic             valid,
  output logic             busy
);

  localparam int               CW     = $clog2(WIDTH);
  localparam logic [WIDTH:0]   ONE_W1 = 1;
  localparam logic [CW-1:0]    LAST   = CW'(WIDTH - 1);

  rng_state_e       state_q;
  rng_state_e       state_d;
  logic             enable_prev;
  logic             req;
  logic             max_all_ones;
  logic             last_step;
  logic             lfsr_load;
  logic [WIDTH-1:0] lfsr_load_val;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH:0]   divisor_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    step_q;
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_step;

`ifdef RNG_SEED_LOAD_EN
  assign lfsr_load     = seed_load;
  assign lfsr_load_val = seed_in;
`else
  assign lfsr_load     = 1'b0;
  assign lfsr_load_val = '0;
`endif

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .state    (lfsr_q)
  );

  assign req          = enable & ~enable_prev;
  assign max_all_ones = &max_value;
  assign last_step    = (step_q == LAST);

  // One restoring-division step: bring in the next dividend bit, subtract if it fits.
  // The remainder is always below the divisor, so it fits in WIDTH bits.
  assign rem_shift = {rem_q, dividend_q[WIDTH-1]};
  assign rem_ge    = (rem_shift >= divisor_q);
  assign rem_step  = rem_ge ? WIDTH'(rem_shift - divisor_q) : rem_shift[WIDTH-1:0];

  assign valid = (state_q == DONE);
  assign busy  = (state_q != IDLE);

  // Next-state logic; DONE always returns to IDLE, so a request landing there is lost.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = max_all_ones ? DONE : DIV;
      DIV:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Edge detector, operand capture, divider datapath and result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_prev   <= 1'b0;
      dividend_q    <= '0;
      divisor_q     <= '0;
      rem_q         <= '0;
      step_q        <= '0;
      random_output <= '0;
    end else begin
      enable_prev <= enable;
      case (state_q)
        IDLE: begin
          if (req) begin
            dividend_q <= lfsr_q;
            divisor_q  <= {1'b0, max_value} + ONE_W1;
            rem_q      <= '0;
            step_q     <= '0;
            // Dividing by 2^WIDTH leaves the value unchanged, so skip the divider.
            if (max_all_ones) begin
              random_output <= lfsr_q;
            end
          end
        end
        DIV: begin
          dividend_q <= {dividend_q[WIDTH-2:0], 1'b0};
          rem_q      <= rem_step;
          step_q     <= step_q + CW'(1);
          if (last_step) begin
            random_output <= rem_step;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
